flit_injector: RTL and testbench
================================

# flit_injector

Credit-based flit transmitter that drives one router input port, from a network interface or an upstream router output. Accepts messages over a valid/ready interface and buffers them in an internal FIFO. Formats each message into a single flit carrying destination and source router IDs, and sends it only when the downstream router has a free VC. Consumes the per-port `upstr_router_increment` pulse that `router_top` returns as its credit-return signal.

## Interface
- `NUM_ROUTERS`, 16, routers in the mesh
- `ROUTER_ID`, 0, ID of the sending node, placed in the flit source field
- `ROUTER_ID_BITS`, `$clog2(NUM_ROUTERS)`, router ID field width
- `NUM_VC`, 4, VCs per downstream input port
- `CREDIT_INIT`, `NUM_VC`, credits after reset (free downstream VCs)
- `QUEUE_DEPTH`, 4, message FIFO entries, power of two, at least 2
- `PAYLOAD_W`, `` `FLIT_DATA_WIDTH-2*ROUTER_ID_BITS ``, message payload width
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-low reset
- `msg_valid`  in  1  message offered
- `msg_dest`  in  `ROUTER_ID_BITS`  destination router
- `msg_payload`  in  `PAYLOAD_W`  message body
- `msg_ready`  out  1  FIFO can accept a message this cycle
- `credit_increment`  in  1  one-cycle credit-return pulse from the downstream router
- `out_data`  out  `` `FLIT_DATA_WIDTH ``  flit to the router `input_data[p]`
- `out_valid`  out  1  flit valid, to the router `input_valid[p]`
- `credit_count`  out  `$clog2(CREDIT_INIT+1)`  current credits
- `credit_err`  out  1  sticky; set on credit overflow
- `sent_count`  out  16  flits sent (statistics)
- `stall_count`  out  16  cycles stalled for credit (statistics)

## Operation
- Flit format, MSB first: `out_data[W-1 -: ROUTER_ID_BITS]` = destination; next `ROUTER_ID_BITS` bits = `ROUTER_ID`; low `PAYLOAD_W` bits = payload.
- Push: a message is written to the FIFO on `msg_valid && msg_ready`.
- `msg_ready`:
  - equals `!full`, derived from the registered occupancy count.
  - forced to 0 while `reset` is low.
- Pop/send: when the FIFO is non-empty and `credit_count > 0`:
  - the head entry is popped and registered into `out_data`.
  - `out_valid` is 1 in the following cycle.
  - `credit_count` is decremented.
- With no pop, `out_valid` is 0 and `out_data` holds its last value.
- The downstream router has no backpressure; every `out_valid` cycle is a transfer.
- FSM is encoded in the state register:
  - IDLE: FIFO empty. Goes to SEND when FIFO is non-empty and credit > 0, or to STALL when FIFO is non-empty and credit = 0.
  - SEND: pop this cycle. Stays in SEND while entries and credits remain. Goes to STALL when credit reaches 0 with entries left. Goes to IDLE when the FIFO drains.
  - STALL: FIFO non-empty, credit = 0. Goes to SEND the cycle after a `credit_increment`.
- Credit arithmetic, applied in one update per cycle:
  - `next = credit - pop + credit_increment`.
  - Pop and increment in the same cycle leave the count unchanged.
  - An increment while `credit_count == CREDIT_INIT` with no pop saturates the count at `CREDIT_INIT` and sets `credit_err`.
- FIFO pointers wrap modulo `QUEUE_DEPTH`.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- A push into an empty FIFO is not bypassed.

## Timing
- Reset, sampled at posedge while `reset == 0`:
  - `out_valid` = 0, `out_data` = 0.
  - FIFO empty, FSM in IDLE.
  - `credit_count` = `CREDIT_INIT`, `credit_err` = 0.
  - `sent_count` = 0, `stall_count` = 0.
- Reset asserted mid-operation discards all queued messages and any in-flight output flit.
- Latency: a message accepted at edge t with credit available pops at edge t+1; `out_valid` is high in cycle t+1..t+2.
- Throughput: one flit per cycle while credits remain.
- A `credit_increment` sampled at edge t allows a pop at edge t+1 at the earliest.
- After reset, at most `CREDIT_INIT` flits go out without a returned credit.

## Configuration
- `FLIT_INJECTOR_STATS_EN` defined:
  - `sent_count` increments on every pop.
  - `stall_count` increments on every cycle in STALL.
  - Both are 16-bit and saturate at 16'hFFFF.
- Not defined: the counter logic is removed; `sent_count` and `stall_count` are tied to 0.

## Test plan
- Reset and single message: hold `reset` low 3 cycles, checking `out_valid=0` and `msg_ready=0`. Release and send `dest=5`, `payload=0xAB`. Expect `out_valid=1` two cycles after acceptance, `out_data = {4'd5, 4'd0, 0xAB}`, and `credit_count` 4 then 3.
- Credit exhaustion: push 6 messages back-to-back with no increments. Expect 4 flits on consecutive cycles, then STALL with `credit_count=0` and `msg_ready=1`. Pulse `credit_increment` twice; expect exactly 2 more flits, one per pulse, each one cycle after its pulse.
- FIFO full: with credit 0, push until `msg_ready=0`, which happens after 4 accepted messages. A fifth `msg_valid` is ignored. Restore credits; expect flits in push order across the pointer wrap.
- Simultaneous send and increment: with `credit_count=2` and a streaming FIFO, assert `credit_increment` on every pop cycle. Expect `credit_count` to stay at 2 and no stall.
- Overflow: with FIFO empty and `credit_count=4`, pulse `credit_increment`. Expect `credit_count=4` and `credit_err=1`, remaining 1 until reset.
- Statistics (macro on): 6 sends with a 10-cycle stall window gives `sent_count=6` and `stall_count=10`. With the macro off, both read 0.

Source files
------------

// File: rtl/flit_injector.sv
// Credit-based single-flit transmitter with a message FIFO feeding one router input port.
// Optional statistics counters are enabled by defining FLIT_INJECTOR_STATS_EN.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 16
`endif

module flit_injector #(
  parameter int NUM_ROUTERS    = 16,
  parameter int ROUTER_ID      = 0,
  parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
  parameter int NUM_VC         = 4,
  parameter int CREDIT_INIT    = NUM_VC,
  parameter int QUEUE_DEPTH    = 4,
  parameter int PAYLOAD_W      = `FLIT_DATA_WIDTH - 2*ROUTER_ID_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               msg_valid,
  input  logic [ROUTER_ID_BITS-1:0]          msg_dest,
  input  logic [PAYLOAD_W-1:0]               msg_payload,
  output logic                               msg_ready,
  input  logic                               credit_increment,
  output logic [`FLIT_DATA_WIDTH-1:0]        out_data,
  output logic                               out_valid,
  output logic [$clog2(CREDIT_INIT+1)-1:0]   credit_count,
  output logic                               credit_err,
  output logic [15:0]                        sent_count,
  output logic [15:0]                        stall_count
);

  localparam int FLIT_W = `FLIT_DATA_WIDTH;
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CR_W   = $clog2(CREDIT_INIT+1);

  localparam logic [ROUTER_ID_BITS-1:0] SRC_ID     = ROUTER_ID_BITS'(ROUTER_ID);
  localparam logic [CNT_W-1:0]          DEPTH_C    = CNT_W'(QUEUE_DEPTH);
  localparam logic [CR_W-1:0]           CREDIT_MAX = CR_W'(CREDIT_INIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  state_e                  state_r, state_next_s;
  logic [FLIT_W-1:0]       mem_r [QUEUE_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]        count_r, cnt_next_s;
  logic [CR_W-1:0]         credit_r, cr_next_s;
  logic                    credit_err_r;
  logic                    overflow_s;
  logic                    push_s, pop_s, full_s;
  logic [FLIT_W-1:0]       out_data_r;
  logic                    out_valid_r;

  assign full_s    = (count_r == DEPTH_C);
  assign msg_ready = reset && !full_s;
  assign push_s    = msg_valid && msg_ready;

  // The state register is kept equal to "what this cycle does": SEND means a pop now.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_SEND:  pop_s = 1'b1;
      ST_IDLE:  pop_s = 1'b0;
      ST_STALL: pop_s = 1'b0;
      default:  pop_s = 1'b0;
    endcase
  end

  // Occupancy and credit updates, one net change per cycle each.
  always_comb begin
    cnt_next_s = count_r;
    cr_next_s  = credit_r;
    overflow_s = 1'b0;
    if (push_s && !pop_s) begin
      cnt_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!push_s && pop_s) begin
      cnt_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = count_r;
    end
    if (pop_s && !credit_increment) begin
      cr_next_s = credit_r - {{(CR_W-1){1'b0}}, 1'b1};
    end else if (!pop_s && credit_increment) begin
      if (credit_r == CREDIT_MAX) begin
        cr_next_s  = credit_r;
        overflow_s = 1'b1;
      end else begin
        cr_next_s  = credit_r + {{(CR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cr_next_s = credit_r;
    end
  end

  // Next state follows from next-cycle occupancy and credit.
  always_comb begin
    state_next_s = ST_IDLE;
    if (cnt_next_s == {CNT_W{1'b0}}) begin
      state_next_s = ST_IDLE;
    end else if (cr_next_s == {CR_W{1'b0}}) begin
      state_next_s = ST_STALL;
    end else begin
      state_next_s = ST_SEND;
    end
  end

  // FSM, pointers, credits and output flit register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      credit_r     <= CREDIT_MAX;
      credit_err_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {FLIT_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      count_r     <= cnt_next_s;
      credit_r    <= cr_next_s;
      out_valid_r <= pop_s;
      if (overflow_s) credit_err_r <= 1'b1;
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        out_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // Storage holds fully formatted flits; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {msg_dest, SRC_ID, msg_payload};
  end

  assign out_data     = out_data_r;
  assign out_valid    = out_valid_r;
  assign credit_count = credit_r;
  assign credit_err   = credit_err_r;

`ifdef FLIT_INJECTOR_STATS_EN
  logic [15:0] sent_r, stall_r;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sent_r  <= 16'h0000;
      stall_r <= 16'h0000;
    end else begin
      if (pop_s && (sent_r != 16'hFFFF)) sent_r <= sent_r + 16'd1;
      if ((state_r == ST_STALL) && (stall_r != 16'hFFFF)) stall_r <= stall_r + 16'd1;
    end
  end

  assign sent_count  = sent_r;
  assign stall_count = stall_r;
`else
  assign sent_count  = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector with a queue-based reference model checked every cycle.
module tb_flit_injector;

  logic        clk = 1'b0;
  logic        reset;
  logic        msg_valid;
  logic [3:0]  msg_dest;
  logic [7:0]  msg_payload;
  logic        msg_ready;
  logic        credit_increment;
  logic [15:0] out_data;
  logic        out_valid;
  logic [2:0]  credit_count;
  logic        credit_err;
  logic [15:0] sent_count;
  logic [15:0] stall_count;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  flit_injector dut (
    .clk              (clk),
    .reset            (reset),
    .msg_valid        (msg_valid),
    .msg_dest         (msg_dest),
    .msg_payload      (msg_payload),
    .msg_ready        (msg_ready),
    .credit_increment (credit_increment),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .credit_count     (credit_count),
    .credit_err       (credit_err),
    .sent_count       (sent_count),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      checks_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of flits, an integer credit pool, counters.
  logic [15:0] m_q [$];
  int          m_credits = 4;
  logic        m_err     = 1'b0;
  logic        m_valid   = 1'b0;
  logic [15:0] m_data    = 16'h0000;
  int          m_sent    = 0;
  int          m_stall   = 0;
  bit          m_live    = 1'b0;
  bit          m_push, m_pop;

  always @(posedge clk) begin
    m_live = 1'b1;
    if (!reset) begin
      m_q.delete();
      m_credits = 4;
      m_err     = 1'b0;
      m_valid   = 1'b0;
      m_data    = 16'h0000;
      m_sent    = 0;
      m_stall   = 0;
    end else begin
      m_push = msg_valid && (m_q.size() < 4);
      m_pop  = (m_q.size() > 0) && (m_credits > 0);
      if ((m_q.size() > 0) && (m_credits == 0) && (m_stall < 65535)) m_stall++;
      m_valid = m_pop;
      if (m_pop) begin
        m_data = m_q.pop_front();
        if (m_sent < 65535) m_sent++;
        m_credits--;
      end
      if (m_push) m_q.push_back({msg_dest, 4'd0, msg_payload});
      if (credit_increment) begin
        if (m_credits == 4) m_err = 1'b1;
        else m_credits++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("out_valid", out_valid, m_valid);
      check("out_data", out_data, m_data);
      check("msg_ready", msg_ready, (reset && (m_q.size() < 4)) ? 1 : 0);
      check("credit_count", credit_count, m_credits);
      check("credit_err", credit_err, m_err);
`ifdef FLIT_INJECTOR_STATS_EN
      check("sent_count", sent_count, m_sent);
      check("stall_count", stall_count, m_stall);
`else
      check("sent_count", sent_count, 0);
      check("stall_count", stall_count, 0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    reset = 1'b0; msg_valid = 1'b0; msg_dest = 4'd0; msg_payload = 8'h00; credit_increment = 1'b0;
    #1;
    check("ready_in_reset_pre", msg_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_valid", out_valid, 0);
      check("reset_ready", msg_ready, 0);
    end

    // Single message
    reset = 1'b1; msg_valid = 1'b1; msg_dest = 4'd5; msg_payload = 8'hAB;
    step();
    msg_valid = 1'b0;
    check("single_credit_before", credit_count, 4);
    check("single_valid_early", out_valid, 0);
    step();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 16'h50AB);
    check("single_credit_after", credit_count, 3);
    step();
    check("single_hold", out_data, 16'h50AB);

    // Credit exhaustion
    credit_increment = 1'b1; step(); credit_increment = 1'b0;
    check("refill_credit", credit_count, 4);
    for (int i = 0; i < 6; i++) begin
      msg_valid = 1'b1; msg_dest = 4'(i + 1); msg_payload = 8'(8'h10 + i);
      step();
      if (i == 1) check("exh_first_flit", out_data, 16'h1010);
    end
    msg_valid = 1'b0;
    repeat (3) step();
    check("exh_credit_zero", credit_count, 0);
    check("exh_ready", msg_ready, 1);
    check("exh_stalled", out_valid, 0);
    credit_increment = 1'b1; step(); credit_increment = 1'b0;
    check("exh_no_same_cycle", out_valid, 0);
    step();
    check("exh_flit5_valid", out_valid, 1);
    check("exh_flit5_data", out_data, 16'h5014);
    repeat (2) step();
    credit_increment = 1'b1; step(); credit_increment = 1'b0;
    step();
    check("exh_flit6_data", out_data, 16'h6015);
`ifdef FLIT_INJECTOR_STATS_EN
    check("stats_sent", sent_count, 7);
    check("stats_stall", stall_count, 8);
`else
    check("stats_sent_off", sent_count, 0);
    check("stats_stall_off", stall_count, 0);
`endif

    // FIFO full with zero credit, then drain across the pointer wrap
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      msg_valid = 1'b1; msg_dest = 4'd7; msg_payload = 8'(8'h20 + k);
      if (msg_ready) acc++;
      step();
    end
    msg_valid = 1'b0;
    check("full_accepted", acc, 4);
    check("full_ready", msg_ready, 0);
    for (int j = 0; j < 5; j++) begin
      credit_increment = (j < 4);
      step();
      if (j > 0) begin
        check("wrap_valid", out_valid, 1);
        check("wrap_data", out_data, 16'h7020 + 16'(j - 1));
      end
    end
    credit_increment = 1'b0;

    // Streaming with an increment on every pop
    credit_increment = 1'b1; repeat (2) step(); credit_increment = 1'b0;
    check("stream_credit_start", credit_count, 2);
    for (int k = 0; k < 6; k++) begin
      msg_valid = (k < 5); msg_dest = 4'd9; msg_payload = 8'(8'h30 + k);
      credit_increment = (k >= 1);
      step();
      check("stream_credit", credit_count, 2);
      if (k >= 1) check("stream_valid", out_valid, 1);
    end
    msg_valid = 1'b0; credit_increment = 1'b0;

    // Overflow
    credit_increment = 1'b1; repeat (2) step(); credit_increment = 1'b0;
    check("ovf_credit_full", credit_count, 4);
    check("ovf_err_clear", credit_err, 0);
    credit_increment = 1'b1; step(); credit_increment = 1'b0;
    check("ovf_credit_sat", credit_count, 4);
    check("ovf_err_set", credit_err, 1);
    repeat (3) step();
    check("ovf_err_sticky", credit_err, 1);

    // Reset mid-operation discards queued and in-flight flits
    for (int k = 0; k < 3; k++) begin
      msg_valid = 1'b1; msg_dest = 4'd3; msg_payload = 8'(8'h40 + k);
      step();
    end
    msg_valid = 1'b0; reset = 1'b0;
    step();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 16'h0000);
    check("rst_credit", credit_count, 4);
    check("rst_err", credit_err, 0);
    check("rst_ready", msg_ready, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_quiet", out_valid, 0);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
